// File: rtl/song_scheduler_if.sv
// Bundle of request, selection and playback signals between the sequencer
// owner (master) and song_scheduler (slave).
interface song_scheduler_if;
    logic       play_req;
    logic       stop_req;
    logic [1:0] song_sel;
    logic [6:0] live_keys;
    logic [6:0] song_keys;
    logic [1:0] song_id;
    logic       song_load;
    logic       song_step;
    logic [6:0] keys_out;
    logic       busy;
    logic       song_done;

    modport master (
        output play_req, stop_req, song_sel, live_keys, song_keys,
        input  song_id, song_load, song_step, keys_out, busy, song_done
    );

    modport slave (
        input  play_req, stop_req, song_sel, live_keys, song_keys,
        output song_id, song_load, song_step, keys_out, busy, song_done
    );
endinterface

// File: rtl/song_scheduler.sv
// Song playback sequencer: IDLE/LOAD/PLAY with live-key override and pause.
// Define SONG_SCHEDULER_LOOP_EN to restart the latched song after its final step.
module song_scheduler #(
    parameter int unsigned TICK_DIV   = 12500000,
    parameter int unsigned NOTE_COUNT = 42
) (
    input logic              clock,
    input logic              resetn,
    song_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    localparam logic [26:0] TICK_RELOAD = 27'(TICK_DIV - 1);
    localparam logic [7:0]  NOTE_LAST   = 8'(NOTE_COUNT - 1);

    state_t      state;
    logic [26:0] tick;
    logic [7:0]  note;
    logic        live_active;
    logic        step;
    logic        final_step;

    // Step and done depend on same-cycle live/stop inputs, so they stay combinational.
    always_comb begin
        live_active   = (bus.live_keys != '0);
        step          = (state == PLAY) && (tick == '0) && !live_active && !bus.stop_req;
        final_step    = step && (note == NOTE_LAST);
        bus.song_step = step;
        bus.song_done = final_step;
        if (live_active)        bus.keys_out = bus.live_keys;
        else if (state == PLAY) bus.keys_out = bus.song_keys;
        else                    bus.keys_out = '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            tick          <= '0;
            note          <= '0;
            bus.song_id   <= '0;
            bus.song_load <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.play_req && !bus.stop_req) begin
                        bus.song_id   <= bus.song_sel;
                        bus.song_load <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    bus.song_load <= 1'b0;
                    tick          <= TICK_RELOAD;
                    note          <= '0;
                    if (bus.stop_req) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (bus.stop_req) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (step) begin
                        tick <= TICK_RELOAD;
                        note <= note + 8'd1;
                        if (final_step) begin
`ifdef SONG_SCHEDULER_LOOP_EN
                            bus.song_load <= 1'b1;
                            state         <= LOAD;
`else
                            bus.busy <= 1'b0;
                            state    <= IDLE;
`endif
                        end
                    end else if (!live_active) begin
                        tick <= tick - 27'd1;
                    end
                end
                default: begin
                    bus.song_load <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
